ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter, the send direction of the mouse link. The existing ps2 receiver only decodes device-to-host packets. This block sends one command byte to the device, for example 0xF4 (enable reporting) or 0xFF (reset), using the PS/2 request-to-send protocol. It reports the device ACK. It drives PS2_CLK/PS2_DAT only through open-drain enables; the top level resolves each line as `oe ? 1'b0 : 1'bz` and shares the line with the receiver.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_line_sync.sv | 26 ++
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command bytes and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE   = 8'hFA;

    // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between a PS/2 host transmitter and its user.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       done;
    logic       ack_ok;
    logic       error;

    modport master (output tx_valid, tx_data, input tx_ready, done, ack_ok, error);
    modport slave  (input tx_valid, tx_data, output tx_ready, done, ack_ok, error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge strobe on the synced level.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;

    // Reset to the idle-high bus level so no spurious edge follows reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter using request-to-send; drives the pins via open-drain enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             ack_q, ack_d;
    logic             tx_ready_q, tx_ready_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             error_q, error_d;

    logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_dat_in),
        .level_o (dat_lvl),
        .fall_o  (dat_fall_unused)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        data_d   = data_q;
        par_d    = par_q;
        ack_d    = ack_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        ack_ok_d = ack_ok_q;
        error_d  = error_q;

        unique case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.tx_valid && tx_ready_q) begin
                    data_d   = bus.tx_data;
                    par_d    = odd_parity(bus.tx_data);
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RTS: begin
                cnt_d    = cnt_q + CNT_W'(1);
                edge_d   = '0;
                clk_oe_d = 1'b0;
                state_d  = SEND;
            end
            SEND, WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TO_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    done_d   = 1'b1;
                    ack_ok_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = IDLE;
                end else if (state_q == SEND) begin
                    // edge_q counts falls already seen; the current fall is edge_q + 1.
                    if (clk_fall) begin
                        edge_d = edge_q + 4'd1;
                        if (edge_q < 4'd8) begin
                            dat_oe_d = ~data_q[edge_q[2:0]];
                        end else if (edge_q == 4'd8) begin
                            dat_oe_d = ~par_q;
                        end else if (edge_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                        end else begin
                            ack_d    = ~dat_lvl;
                            dat_oe_d = 1'b0;
                            state_d  = WAIT_IDLE;
                        end
                    end
                end else if (clk_lvl && dat_lvl) begin
                    done_d   = 1'b1;
                    ack_ok_d = ack_q;
                    error_d  = ~ack_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_ready_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            ack_q      <= 1'b0;
            tx_ready_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            ack_q      <= ack_d;
            tx_ready_q <= tx_ready_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        par_q  <= par_d;
    end

    assign bus.tx_ready = tx_ready_q;
    assign bus.done     = done_q;
    assign bus.ack_ok   = ack_ok_q;
    assign bus.error    = error_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_dat_oe   = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines checks frames, ACK status and timing.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();
    logic ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic clk_line, dat_line;
    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    string cur = "init";

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h, want %0h", cur, name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        chk("tx_ready_idle", 32'(bus.tx_ready), 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic measure_inhibit(output int hi, output int ndat, output int rts);
        hi = 0; ndat = 0; rts = -1;
        for (int i = 0; i < INH + 50; i++) begin
            @(negedge clk);
            if (ps2_clk_oe !== 1'b1) break;
            hi++;
            if (ps2_dat_oe === 1'b1) begin
                ndat++;
                rts = cyc;
            end
        end
        chk("start_bit_held", 32'(ps2_dat_oe), 1);
    endtask

    task automatic device(input int n_edges, input bit ack, input int inject, output logic [10:0] got);
        got = '0;
        tick(HALF);
        got[0] = dat_line;
        for (int k = 1; k <= n_edges && k <= 10; k++) begin
            dev_clk_low = 1'b1;
            if (k == inject) begin
                tick(1);
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'h00;
                tick(1);
                bus.tx_valid = 1'b0;
                tick(HALF - 2);
            end else begin
                tick(HALF);
            end
            dev_clk_low = 1'b0;
            got[k] = dat_line;
            tick(HALF);
        end
        if (n_edges >= 11) begin
            dev_dat_low = ack;
            tick(5);
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input logic [7:0] d, input bit dev_ack, input bit dev_clocks,
                           input int inject, input bit exp_ack, input bit exp_err);
        int hi, ndat, rts, n0;
        logic [10:0] got;
        bit ok;
        n0 = done_cnt;
        start_tx(d);
        measure_inhibit(hi, ndat, rts);
        chk("clk_oe_cycles", 32'(hi), 32'(INH + 1));
        chk("rts_dat_cycles", 32'(ndat), 1);
        if (dev_clocks) begin
            device(11, dev_ack, inject, got);
            chk("frame", 32'(got), 32'(model_frame(d)));
            if (d == PS2_CMD_ENABLE) chk("frame_f4", 32'(got), 32'h5E8);
            wait_done(100, ok);
        end else begin
            wait_done(TO + 50, ok);
        end
        chk("done_seen", 32'(ok), 1);
        if (ok) begin
            chk("ack_ok", 32'(bus.ack_ok), 32'(exp_ack));
            chk("error", 32'(bus.error), 32'(exp_err));
            chk("oe_at_done", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
            chk("ready_in_done", 32'(bus.tx_ready), 0);
            if (!dev_clocks) chk("timeout_latency", 32'(cyc - rts), 32'(TO));
            @(negedge clk);
            chk("ready_after_done", 32'(bus.tx_ready), 1);
            chk("status_hold", 32'({bus.done, bus.ack_ok, bus.error}), 32'({1'b0, exp_ack, exp_err}));
        end
        tick(20);
        chk("one_done", 32'(done_cnt - n0), 1);
        chk("stays_idle", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         dev_ack;
        bit         dev_clocks;
        int         inject;
        bit         exp_ack_ok;
        bit         exp_error;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n0;
        logic [10:0] got;
        int hi, ndat, rts;
        logic [7:0] rd;
        bit ra;

        vecs[0] = '{PS2_CMD_ENABLE, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[1] = '{PS2_CMD_RESET,  1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[2] = '{PS2_CMD_ENABLE, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[3] = '{8'h00,          1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[4] = '{8'hA5,          1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[5] = '{PS2_CMD_ENABLE, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[6] = '{PS2_CMD_ENABLE, 1'b1, 1'b1, 5, 1'b1, 1'b0};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        tick(3);
        @(negedge clk);
        cur = "reset";
        chk("tx_ready", 32'(bus.tx_ready), 1);
        chk("clk_oe", 32'(ps2_clk_oe), 0);
        chk("dat_oe", 32'(ps2_dat_oe), 0);
        chk("done", 32'(bus.done), 0);
        chk("ack_ok", 32'(bus.ack_ok), 0);
        chk("error", 32'(bus.error), 0);
        reset_n = 1'b1;
        tick(5);

        for (int i = 0; i < 7; i++) begin
            cur = $sformatf("vec%0d_%02h", i, vecs[i].data);
            run_vec(vecs[i].data, vecs[i].dev_ack, vecs[i].dev_clocks, vecs[i].inject,
                    vecs[i].exp_ack_ok, vecs[i].exp_error);
        end

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            cur = $sformatf("rand%0d_%02h", i, rd);
            run_vec(rd, ra, 1'b1, 0, ra, !ra);
        end

        // Reset lands mid-frame after the fourth device clock edge.
        cur = "reset_mid";
        n0 = done_cnt;
        start_tx(PS2_CMD_ENABLE);
        measure_inhibit(hi, ndat, rts);
        device(4, 1'b0, 0, got);
        chk("partial_frame", 32'(got[4:0]), 32'(model_frame(PS2_CMD_ENABLE) & 11'h01F));
        chk("dat_oe_before_reset", 32'(ps2_dat_oe), 1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("clk_oe", 32'(ps2_clk_oe), 0);
        chk("dat_oe", 32'(ps2_dat_oe), 0);
        chk("tx_ready", 32'(bus.tx_ready), 1);
        chk("done", 32'(bus.done), 0);
        reset_n = 1'b1;
        tick(TO + 100);
        chk("no_done", 32'(done_cnt - n0), 0);
        chk("idle_after_reset", 32'({ps2_clk_oe, ps2_dat_oe}), 0);
        cur = "after_reset_ff";
        run_vec(PS2_CMD_RESET, 1'b1, 1'b1, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
